dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the 32-word data memory. It shares the single `data_mem` port between the pipeline MEM stage (port 0) and a debug/loader master (port 1), and runs each access as a fixed three-state sequence. It also rejects misaligned or out-of-range addresses, and returns registered read data with a one-cycle `ready` pulse to the winning requester. It sits between the MEM stage, the debug master and `data_mem`.

## Interface
- `DEPTH_WORDS`, 32: number of memory words; legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
- `MAX_WAIT`, 4: number of lost arbitration cycles after which port 1 is promoted. Used only with `DMEM_ARB_STARVE_EN`.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `req0` / `req1` in 1: access request; held until `ready` is seen.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in 32: byte address.
- `wdata0` / `wdata1` in 32: write data.
- `ready0` / `ready1` out 1: one-cycle completion pulse.
- `err0` / `err1` out 1: valid with `ready`; 1 = address rejected, no memory access made.
- `rdata0` / `rdata1` out 32: read data, valid while `ready` is high; 0 for writes and errors.
- `mem_r_enable` out 1: drives `data_mem` `r_enable`.
- `mem_w_enable` out 1: drives `data_mem` `w_enable`.
- `mem_address` out 32: drives `data_mem` `address`.
- `mem_wr_data` out 32: drives `data_mem` `wr_data`.
- `mem_re_data` in 32: driven from `data_mem` `re_data` (combinational).

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: drive memory from the latched request.
  - DONE: pulse `ready` to the owner.
- IDLE → ACCESS when any `req` is high. At that edge, latch the winner's `owner`, `we`, `addr` and `wdata`, and compute `bad = (addr[1:0]!=0) | (addr >= 4*DEPTH_WORDS)`.
- Arbitration: fixed priority, port 0 wins when both request (see Configuration for the exception).
- ACCESS:
  - `mem_address = addr_q`, `mem_wr_data = wdata_q`.
  - `mem_w_enable = we_q & !bad_q & !rst`.
  - `mem_r_enable = !we_q & !bad_q & !rst`.
  - At the ending edge, capture `rdata_q = (!we_q & !bad_q) ? mem_re_data : 0` and `err_q = bad_q`. The write commits on this same edge.
- ACCESS → DONE unconditionally.
- DONE: `ready[owner]=1`, `rdata[owner]=rdata_q`, `err[owner]=err_q`. The non-owner port's outputs are 0.
- DONE → IDLE unconditionally. Requesters must drop or replace `req` by the edge that ends DONE; `req` high in IDLE is always treated as a new request.
- Outside ACCESS, all `mem_*` outputs are 0. Outside DONE, all `ready`, `err` and `rdata` outputs are 0.

## Timing
- Latency: `req` high in IDLE cycle N → ACCESS in N+1 → `ready` in N+2. Throughput is one access per 3 cycles.
- Back-to-back: a loser still requesting is arbitrated in the next IDLE after DONE.
- Reset: state=IDLE, `owner`=0, all latched registers, outputs and the starvation counter are 0.
- `rst` during ACCESS:
  - `mem_w_enable` is forced to 0, so no write occurs.
  - No `ready` is issued; the transaction is lost and the requester must re-request.
- `rst` during DONE: the `ready` pulse is suppressed from the next cycle on.
- Input changes while the arbiter is in ACCESS or DONE have no effect; the request is latched only at IDLE.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - A counter (width $clog2(MAX_WAIT+1)) increments on each IDLE cycle where `req1` is high and port 0 wins, saturating at `MAX_WAIT`.
  - When the counter equals `MAX_WAIT`, port 1 wins the next IDLE arbitration even if `req0` is high.
  - The counter clears when port 1 is granted.
- `DMEM_ARB_STARVE_EN` undefined: pure fixed priority to port 0. There is no counter and `MAX_WAIT` is unused.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 → `ready0` 2 cycles after each request is accepted; the read gives `rdata0`=0xDEADBEEF, `err0`=0, and `mem_w_enable` is high for exactly one cycle.
- `req0` and `req1` rise in the same cycle (port 0 reads 0x04, port 1 reads 0x08) → port 0 completes first. Port 1 is accepted in the next IDLE, and `ready1` arrives 3 cycles after `ready0`.
- Port 1 writes to 0x06 (misaligned), then to 0x80 (out of range, DEPTH 32) → `ready1`=1 with `err1`=1, `rdata1`=0, `mem_w_enable` never asserted, and memory contents unchanged.
- With `DMEM_ARB_STARVE_EN` and `MAX_WAIT`=4: `req0` held high continuously and `req1` held high → port 1 is granted after port 0 has won 4 IDLE arbitrations while port 1 waited. Without the macro, port 1 is never granted.
- `rst` asserted in the ACCESS cycle of a port 0 write of 0x12345678 to 0x0C → no `ready0`, a subsequent read of 0x0C returns the old value, and all outputs are 0 during reset.
- Port 1 write of 0xCAFEF00D to 0x7C (last word), then port 0 read of 0x7C → `rdata0`=0xCAFEF00D, `err0`=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data_mem port between the pipeline MEM stage (port 0)
//   and a debug/loader master (port 1). Every access runs the fixed sequence
//   IDLE -> ACCESS -> DONE, so throughput is one access per three cycles.
//
//   Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
//   it until readyN; readyN is a one-cycle pulse with errN/rdataN valid in the
//   same cycle. The request is latched only in IDLE, and a req still high in
//   IDLE after DONE is a fresh request.
//
//   Optional feature macro: DMEM_ARB_STARVE_EN
//     defined   - port 1 is promoted after losing MAX_WAIT arbitrations.
//     undefined - pure fixed priority to port 0; MAX_WAIT is unused.
//
//   dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 DONE).
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 32,
    parameter int MAX_WAIT    = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ready0,
    output logic        err0,
    output logic [31:0] rdata0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ready1,
    output logic        err1,
    output logic [31:0] rdata1,

    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_re_data,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // First illegal byte address; anything at or above it is rejected.
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state_q;
    state_t      state_d;

    // Latched transaction
    logic        owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        bad_q;

    // Completion results presented during DONE
    logic [31:0] rdata_q;
    logic        err_q;

    // Arbitration
    logic        any_req;
    logic        grant1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    assign any_req = req0 | req1;

`ifdef DMEM_ARB_STARVE_EN
    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic             starve_hit;

    assign starve_hit = (starve_cnt_q == CNT_MAX);
    // Port 1 takes the grant when alone, or when it has waited long enough.
    assign grant1     = req1 & (~req0 | starve_hit);

    // Count IDLE arbitrations port 1 lost; clear when port 1 is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            if (grant1) begin
                starve_cnt_q <= '0;
            end else if (req1 && !starve_hit) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting.
    assign grant1 = req1 & ~req0;
`endif

    // Select the winning request and classify its address.
    always_comb begin
        sel_we    = grant1 ? we1    : we0;
        sel_addr  = grant1 ? addr1  : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        sel_bad   = (sel_addr[1:0] != 2'b00) | (sel_addr >= ADDR_LIMIT);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave IDLE on any request, then walk ACCESS and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner in IDLE and capture the memory result at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant1;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        bad_q   <= sel_bad;
                    end
                end
                ACCESS: begin
                    rdata_q <= (!we_q && !bad_q) ? mem_re_data : '0;
                    err_q   <= bad_q;
                end
                default: ;
            endcase
        end
    end

    // Drive memory only in ACCESS and the requester outputs only in DONE.
    // Reset gates the memory side at once so a write in flight never commits.
    always_comb begin
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        mem_address  = '0;
        mem_wr_data  = '0;
        ready0       = 1'b0;
        err0         = 1'b0;
        rdata0       = '0;
        ready1       = 1'b0;
        err1         = 1'b0;
        rdata1       = '0;
        case (state_q)
            ACCESS: begin
                if (!rst) begin
                    mem_address  = addr_q;
                    mem_wr_data  = wdata_q;
                    mem_w_enable = we_q & ~bad_q;
                    mem_r_enable = ~we_q & ~bad_q;
                end
            end
            DONE: begin
                if (owner_q) begin
                    ready1 = 1'b1;
                    err1   = err_q;
                    rdata1 = rdata_q;
                end else begin
                    ready0 = 1'b1;
                    err0   = err_q;
                    rdata0 = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule
